wb_keys: RTL
============

Name: wb_keys

Overview:
- Wishbone slave that debounces the board push-buttons and slide switches and reports them to the CPU.
- Latches press, release and change events and raises a level interrupt.
- Sits upstream of the interrupt vector and mapped on the spare interconnect slave slot 6 at 0xF0030000; replaces the raw key/switch use for firmware input.

Parameters:
- clk_freq, 50000000: system clock in Hz; the 1 ms prescaler terminal count is clk_freq/1000-1.
- debounce_ms, 10: number of consecutive 1 ms ticks an input must differ from its debounced state before the state flips. Range 1..255.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- wb_adr_i, input, 32: byte address; only [3:2] decoded.
- wb_dat_i, input, 32: write data.
- wb_dat_o, output, 32: read data.
- wb_sel_i, input, 4: byte lane enables for writes.
- wb_stb_i, input, 1: strobe.
- wb_cyc_i, input, 1: cycle.
- wb_we_i, input, 1: write enable.
- wb_ack_o, output, 1: acknowledge.
- intr, output, 1: active-high level interrupt.
- key_n, input, 4: push-buttons, active-low, asynchronous to clk.
- sw, input, 10: slide switches, asynchronous to clk.

Behaviour:
- Reset values:
  - wb_ack_o=0, wb_dat_o=0, intr=0.
  - Prescaler=0, all debounce counters=0.
  - Debounced key state=0 (released); debounced sw state=0.
  - EVENT=0, MASK=0, armed=0, arm counter=0.
- Synchronisers: each of the 14 inputs passes through 2 flip-flops. Keys are inverted after synchronisation, giving pressed=1.
- Prescaler:
  - Counts 0..clk_freq/1000-1, then wraps to 0.
  - tick is asserted for exactly one clk when the count equals the terminal value.
- Per-input debounce:
  - If the synchronised input equals the debounced state, the counter clears to 0.
  - Otherwise, on each tick the counter increments.
  - When the counter reaches debounce_ms on a tick, the debounced state takes the input value, the counter clears, and a one-cycle edge strobe is produced.
  - A glitch shorter than debounce_ms ticks never changes the state.
- Arming:
  - The arm counter increments on each tick while armed=0.
  - Once it reaches debounce_ms+1, armed=1 and stays 1 until reset.
  - While armed=0, edge strobes update the debounced state but set no EVENT bits. Switches already high at reset therefore do not interrupt.
- Register map (word index wb_adr_i[3:2]; unused bits read 0):
  - 0 STATE, RO: [3:0] debounced keys, [25:16] debounced sw.
  - 1 EVENT, W1C: [3:0] key press, [7:4] key release, [25:16] sw change (either direction).
  - 2 MASK, RW: same bit layout as EVENT; unused bits read 0 and ignore writes.
  - 3 RAW, RO: [3:0] synchronised inverted keys, [25:16] synchronised sw.
- Wishbone timing:
  - ack rises on the clk after cyc&stb&~ack, and is held one cycle.
  - Back-to-back accesses therefore take 2 cycles each.
  - Read data is registered in the same edge that asserts ack.
  - Writes take effect on the edge that asserts ack, per byte lane under wb_sel_i.
  - Writes to STATE and RAW are acked and ignored.
  - Deassertion of stb or cyc before ack aborts the access with no side effect.
- EVENT rules:
  - A bit is set by an edge strobe when armed.
  - A bit is cleared by writing 1 in an enabled lane.
  - If a set and a clear hit the same bit on the same cycle, set wins.
  - Bits are sticky; a repeated event while already set is a no-op.
- intr is registered: intr <= |(EVENT & MASK). It is visible 1 clk after an EVENT or MASK change.
- Reset asserted mid-transfer: ack drops immediately (asynchronous), and all state returns to reset values.

Test Plan:
1. Reset, with sw[3]=1 held and clk_freq scaled to 1000 (tick every clk), debounce_ms=3 → after 4 ticks STATE[19]=1, EVENT=0, intr=0.
2. With MASK=0x1 written, hold key_n[0]=0 for 3 ticks → STATE[0]=1, EVENT[0]=1, intr=1 one clk later. Then release for 3 ticks → EVENT[4]=1, intr stays 1.
3. Pulse key_n[1]=0 for 2 ticks, then 1 → STATE[1]=0 throughout, EVENT[1]=0, RAW[1] follows the pulse.
4. Write EVENT=0x00000001 with sel=4'b0001 on the same cycle that a key0 press strobe fires → EVENT[0] remains 1. Write 0x1 again with no event → EVENT[0]=0 and intr=0 on the next clk.
5. Write MASK=0xFFFFFFFF with sel=4'b0011, then read → 0x000000FF. Read STATE after writing 0x12345678 to it → value unchanged. Every access is acked exactly 1 cycle after stb.
6. Assert reset while an ack is high and EVENT=0x10001 → ack, intr and EVENT are 0 immediately, and the next read of MASK returns 0.

Source files
------------

// File: rtl/wb_keys.sv
// Wishbone key/switch debouncer: 2-FF synchronisers, 1 ms tick, per-input debounce,
// sticky W1C event register with mask and a registered level interrupt.
module wb_keys #(
    parameter int clk_freq    = 50000000,
    parameter int debounce_ms = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic [3:0]  key_n,
    input  logic [9:0]  sw
);

    localparam logic [31:0] PRESC_TC = 32'(clk_freq / 1000 - 1);
    localparam logic [7:0]  DB_LAST  = 8'(debounce_ms - 1);
    localparam logic [8:0]  ARM_TC   = 9'(debounce_ms + 1);
    localparam logic [31:0] EV_BITS  = 32'h03FF_00FF;

    logic [31:0] r_presc;
    logic        w_tick;

    logic [3:0]  r_key_s1, r_key_s2;
    logic [9:0]  r_sw_s1, r_sw_s2;
    logic [13:0] w_raw;

    logic [7:0]  r_cnt [14];
    logic [13:0] r_state;
    logic [13:0] w_edge;

    logic [8:0]  r_arm_cnt;
    logic        r_armed;

    logic [31:0] r_event;
    logic [31:0] r_mask;
    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_intr;

    logic        w_req;
    logic        w_wr;
    logic [1:0]  w_idx;
    logic [31:0] w_lane;
    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    assign w_tick = (r_presc == PRESC_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 32'd1;
        end
    end

    // Key synchronisers idle at 1 (released) so reset does not look like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1 <= '1;
            r_key_s2 <= '1;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
        end else begin
            r_key_s1 <= key_n;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
        end
    end

    assign w_raw = {r_sw_s2, ~r_key_s2};

    always_comb begin
        w_edge = '0;
        for (int i = 0; i < 14; i++) begin
            w_edge[i] = w_tick && (w_raw[i] != r_state[i]) && (r_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= '0;
            for (int i = 0; i < 14; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 14; i++) begin
                if (w_raw[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_edge[i]) begin
                    r_state[i] <= w_raw[i];
                    r_cnt[i]   <= '0;
                end else if (w_tick) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Armed is registered from the count, so strobes caused by inputs already
    // active at reset land one cycle before it rises and are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (r_arm_cnt == ARM_TC) begin
                r_armed <= 1'b1;
            end else if (w_tick) begin
                r_arm_cnt <= r_arm_cnt + 9'd1;
            end
        end
    end

    always_comb begin
        w_set = '0;
        if (r_armed) begin
            w_set[3:0]   = w_edge[3:0] & w_raw[3:0];
            w_set[7:4]   = w_edge[3:0] & ~w_raw[3:0];
            w_set[25:16] = w_edge[13:4];
        end
    end

    assign w_req  = wb_cyc_i && wb_stb_i && !r_ack;
    assign w_wr   = w_req && wb_we_i;
    assign w_idx  = wb_adr_i[3:2];
    assign w_lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign w_clr  = (w_wr && w_idx == 2'd1) ? (wb_dat_i & w_lane) : '0;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            2'd0:    w_rdata = {6'b0, r_state[13:4], 12'b0, r_state[3:0]};
            2'd1:    w_rdata = r_event;
            2'd2:    w_rdata = r_mask;
            default: w_rdata = {6'b0, w_raw[13:4], 12'b0, w_raw[3:0]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_event <= '0;
            r_mask  <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_intr  <= |(r_event & r_mask);
            // Set has priority over a simultaneous W1C clear.
            r_event <= ((r_event & ~w_clr) | w_set) & EV_BITS;
            if (w_wr && w_idx == 2'd2) begin
                r_mask <= ((r_mask & ~w_lane) | (wb_dat_i & w_lane)) & EV_BITS;
            end
            if (w_req && !wb_we_i) begin
                r_dat <= w_rdata;
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign intr     = r_intr;

endmodule
